// File: rtl/char_rotator_if.sv
// Purpose: bundles the pattern/control inputs and the character outputs of char_rotator.
// Latency: none, this interface is wiring only.
// Backpressure: none; every signal is a level, and Tick is a one-cycle pulse.
// Ports: C/Load/Run/Step/Dir are driven toward the rotator.
//        M2/M1/M0/Pos/Tick are driven back from it.
interface char_rotator_if;
  logic [5:0] C;
  logic       Load;
  logic       Run;
  logic       Step;
  logic       Dir;
  logic [1:0] M2;
  logic [1:0] M1;
  logic [1:0] M0;
  logic [1:0] Pos;
  logic       Tick;

  modport master (
    output C, Load, Run, Step, Dir,
    input  M2, M1, M0, Pos, Tick
  );

  modport slave (
    input  C, Load, Run, Step, Dir,
    output M2, M1, M0, Pos, Tick
  );
endinterface

// File: rtl/char_rotator.sv
// Purpose: rotates a 3-character pattern across HEX2/HEX1/HEX0, either on a prescaled timebase or one position per Step press.
// Latency: M/Pos follow the advancing edge with no extra pipeline; Load reaches M at the next edge.
// Backpressure: none; Step edges seen while Run=1 or during Load are dropped rather than queued.
// Ports: CLOCK_50 clock; Reset sync active-high; bus.C/Load/Run/Step/Dir control inputs;
//        bus.M2/M1/M0 character codes, bus.Pos rotation index 0..2, bus.Tick advance pulse.
module char_rotator #(
  parameter int TICKS = 50_000_000
) (
  input  logic          CLOCK_50,
  input  logic          Reset,
  char_rotator_if.slave bus
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS - 1);

  logic [5:0]    pat;
  logic [1:0]    pos;
  logic [CW-1:0] cnt;
  logic          step_q;
  logic          tick;

  logic          step_edge;
  logic          cnt_wrap;
  logic          advance;
  logic [1:0]    pos_next;

  assign step_edge = bus.Step & ~step_q;
  assign cnt_wrap  = (cnt == CNT_LAST);

  // Load outranks both advance sources; Run selects which source is live.
  always_comb begin
    advance = 1'b0;
    if (!bus.Load) begin
      advance = bus.Run ? cnt_wrap : step_edge;
    end
  end

  // Modulo-3 step in either direction; Pos never reaches 3.
  always_comb begin
    pos_next = pos;
    if (bus.Dir) begin
      pos_next = (pos == 2'd0) ? 2'd2 : pos - 2'd1;
    end else begin
      pos_next = (pos == 2'd2) ? 2'd0 : pos + 2'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      pat    <= 6'b00_01_10;
      pos    <= 2'd0;
      cnt    <= '0;
      step_q <= 1'b0;
      tick   <= 1'b0;
    end else begin
      step_q <= bus.Step;
      tick   <= advance;
      if (bus.Load) begin
        pat <= bus.C;
        pos <= 2'd0;
        cnt <= '0;
      end else begin
        if (advance) begin
          pos <= pos_next;
        end
        // Prescaler only counts while Run is high, so dropping Run restarts the interval.
        if (bus.Run && !cnt_wrap) begin
          cnt <= cnt + CW'(1);
        end else begin
          cnt <= '0;
        end
      end
    end
  end

  // Output mapping depends only on registered state.
  always_comb begin
    bus.M2 = pat[5:4];
    bus.M1 = pat[3:2];
    bus.M0 = pat[1:0];
    case (pos)
      2'd1: begin
        bus.M2 = pat[3:2];
        bus.M1 = pat[1:0];
        bus.M0 = pat[5:4];
      end
      2'd2: begin
        bus.M2 = pat[1:0];
        bus.M1 = pat[5:4];
        bus.M0 = pat[3:2];
      end
      default: begin
        bus.M2 = pat[5:4];
        bus.M1 = pat[3:2];
        bus.M0 = pat[1:0];
      end
    endcase
  end

  assign bus.Pos  = pos;
  assign bus.Tick = tick;

endmodule

// File: tb/tb_char_rotator.sv
// Purpose: self-checking bench for char_rotator with TICKS=4, scoreboarded against a behavioural model.
// Latency: expected values are queued at drive time and compared 1 time unit after the next rising edge.
// Backpressure: none; stimulus is fixed-length, so the run always ends.
module tb_char_rotator;

  localparam int TK = 4;

  logic clk;
  logic rst;
  char_rotator_if bus ();

  char_rotator #(.TICKS(TK)) dut (
    .CLOCK_50 (clk),
    .Reset    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] m2;
    logic [1:0] m1;
    logic [1:0] m0;
    logic [1:0] pos;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Model state.
  logic [5:0] mp;
  int         mpos;
  int         mcnt;
  logic       mstep;
  logic       mtick;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, req);
    end
  endtask

  function automatic exp_t model_out();
    logic [1:0] ch [3];
    exp_t e;
    ch[0] = mp[5:4];
    ch[1] = mp[3:2];
    ch[2] = mp[1:0];
    e.m2   = ch[mpos % 3];
    e.m1   = ch[(mpos + 1) % 3];
    e.m0   = ch[(mpos + 2) % 3];
    e.pos  = 2'(mpos);
    e.tick = mtick;
    return e;
  endfunction

  // One clock: drive inputs, advance the model, queue expectation, then compare after the edge.
  task automatic cyc(input logic r, input logic ld, input logic rn, input logic st,
                     input logic dr, input logic [5:0] c);
    logic adv;
    exp_t got;
    exp_t e;
    @(negedge clk);
    rst      = r;
    bus.Load = ld;
    bus.Run  = rn;
    bus.Step = st;
    bus.Dir  = dr;
    bus.C    = c;
    adv = 1'b0;
    if (r) begin
      mp = 6'b00_01_10; mpos = 0; mcnt = 0; mstep = 1'b0;
    end else begin
      if (ld) begin
        mp = c; mpos = 0; mcnt = 0;
      end else if (rn) begin
        mcnt++;
        if (mcnt == TK) begin
          mcnt = 0;
          adv  = 1'b1;
        end
      end else begin
        mcnt = 0;
        adv  = st && !mstep;
      end
      if (adv) mpos = dr ? (mpos + 2) % 3 : (mpos + 1) % 3;
      mstep = st;
    end
    mtick = adv;
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    got.m2 = bus.M2; got.m1 = bus.M1; got.m0 = bus.M0;
    got.pos = bus.Pos; got.tick = bus.Tick;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 8'd0, 8'd1);
    end else begin
      e = exp_q.pop_front();
      chk("sb_m2",   8'(got.m2),   8'(e.m2));
      chk("sb_m1",   8'(got.m1),   8'(e.m1));
      chk("sb_m0",   8'(got.m0),   8'(e.m0));
      chk("sb_pos",  8'(got.pos),  8'(e.pos));
      chk("sb_tick", 8'(got.tick), 8'(e.tick));
    end
  endtask

  task automatic chk_m(input string tag, input logic [5:0] req);
    chk({tag, "_m"}, {2'b00, bus.M2, bus.M1, bus.M0}, {2'b00, req});
  endtask

  initial begin
    logic [11:0] tmask;
    int nticks;
    rst = 1'b0; bus.Load = 1'b0; bus.Run = 1'b0; bus.Step = 1'b0; bus.Dir = 1'b0; bus.C = 6'd0;
    mp = 6'b00_01_10; mpos = 0; mcnt = 0; mstep = 1'b0; mtick = 1'b0;

    // Reset with random other inputs.
    for (int i = 0; i < 2; i++)
      cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 6'($urandom));
    chk_m("rst", 6'b00_01_10);
    chk("rst_pos", 8'(bus.Pos), 8'd0);
    chk("rst_tick", 8'(bus.Tick), 8'd0);

    // Auto rotate left.
    tmask = '0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
      tmask[i-1] = bus.Tick;
      if (i == 4) begin
        chk("left_pos1", 8'(bus.Pos), 8'd1);
        chk_m("left_p1", 6'b01_10_00);
      end
      if (i == 8)  chk("left_pos2", 8'(bus.Pos), 8'd2);
      if (i == 12) chk("left_pos0", 8'(bus.Pos), 8'd0);
    end
    chk("left_ticks", 8'(tmask[11:4]), 8'b1000_1000);
    chk("left_tick4", 8'(tmask[3:0]), 8'b1000);

    // Auto rotate right.
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0);
      if (i == 4) begin
        chk("right_pos2", 8'(bus.Pos), 8'd2);
        chk_m("right_p2", 6'b10_00_01);
      end
      if (i == 8)  chk("right_pos1", 8'(bus.Pos), 8'd1);
      if (i == 12) chk("right_pos0", 8'(bus.Pos), 8'd0);
    end

    // Step held high for 5 cycles gives one advance.
    nticks = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
      nticks += int'(bus.Tick);
    end
    chk("step_once", 8'(nticks), 8'd1);
    chk("step_pos1", 8'(bus.Pos), 8'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    chk("step_pos2", 8'(bus.Pos), 8'd2);
    chk("step_tick", 8'(bus.Tick), 8'd1);

    // Step pulses while Run=1 are discarded.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 6'd0);
    chk("run_step_pos", 8'(bus.Pos), 8'd2);

    // Load coincident with a Step rising edge.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b11_10_01);
    chk("load_pos", 8'(bus.Pos), 8'd0);
    chk_m("load", 6'b11_10_01);
    chk("load_tick", 8'(bus.Tick), 8'd0);
    nticks = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
      nticks += int'(bus.Tick);
    end
    chk("load_nodelay", 8'(nticks), 8'd0);
    chk("load_hold_pos", 8'(bus.Pos), 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);

    // Reset at cnt=2, then the next Tick is 4 edges after release.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    chk_m("mid_rst", 6'b00_01_10);
    chk("mid_rst_pos", 8'(bus.Pos), 8'd0);
    tmask = '0;
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
      tmask[i-1] = bus.Tick;
    end
    chk("mid_rst_ticks", 8'(tmask[5:0]), 8'b00_1000);

    // Random traffic through the scoreboard.
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 6'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
